// File: rtl/ram_wr_rd_check.sv
// RAM write-then-readback checker: fills DEPTH words with an address+seed pattern
// through port A, reads them back through port B and counts mismatches.
module ram_wr_rd_check #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 128,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ram_en_a,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_en_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        LAST_DRAIN = 2'(RD_LATENCY - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] seed, seed_nxt;
  logic [1:0]        drain_cnt, drain_cnt_nxt;

  logic              en_a_nxt, wea_nxt, en_b_nxt, busy_nxt, done_nxt;
  logic [ADDR_W-1:0] addr_a_nxt, addr_b_nxt;
  logic [DATA_W-1:0] wr_data_nxt;

  logic                  pipe_vld [RD_LATENCY];
  logic [DATA_W-1:0]     pipe_exp [RD_LATENCY];

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] s);
    return DATA_W'(addr) + s;
  endfunction

  // Outputs are registered from the next-state decode so they line up with the state.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves one unassigned (no latch).
    state_nxt     = state;
    seed_nxt      = seed;
    drain_cnt_nxt = drain_cnt;
    en_a_nxt      = 1'b0;
    wea_nxt       = 1'b0;
    addr_a_nxt    = '0;
    wr_data_nxt   = '0;
    en_b_nxt      = 1'b0;
    addr_b_nxt    = '0;
    done_nxt      = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_nxt   = WRITE;
        en_a_nxt    = 1'b1;
        wea_nxt     = 1'b1;
        wr_data_nxt = pattern('0, seed);
      end
      WRITE: if (ram_addr_a == LAST_ADDR) begin
        state_nxt = READ;
        en_b_nxt  = 1'b1;
      end else begin
        en_a_nxt    = 1'b1;
        wea_nxt     = 1'b1;
        addr_a_nxt  = ram_addr_a + ADDR_W'(1);
        wr_data_nxt = pattern(addr_a_nxt, seed);
      end
      READ: if (ram_addr_b == LAST_ADDR) begin
        state_nxt     = DRAIN;
        drain_cnt_nxt = '0;
      end else begin
        en_b_nxt   = 1'b1;
        addr_b_nxt = ram_addr_b + ADDR_W'(1);
      end
      DRAIN: if (drain_cnt == LAST_DRAIN) begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end else begin
        drain_cnt_nxt = drain_cnt + 2'd1;
      end
      DONE: begin
        state_nxt = IDLE;
        seed_nxt  = seed + DATA_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      seed        <= '0;
      drain_cnt   <= '0;
      ram_en_a    <= 1'b0;
      ram_wea     <= 1'b0;
      ram_addr_a  <= '0;
      ram_wr_data <= '0;
      ram_en_b    <= 1'b0;
      ram_addr_b  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      seed        <= seed_nxt;
      drain_cnt   <= drain_cnt_nxt;
      ram_en_a    <= en_a_nxt;
      ram_wea     <= wea_nxt;
      ram_addr_a  <= addr_a_nxt;
      ram_wr_data <= wr_data_nxt;
      ram_en_b    <= en_b_nxt;
      ram_addr_b  <= addr_b_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  // Expected word and valid bit travel alongside the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this pipeline is a handful of flops, not a RAM, so it is reset to keep stale valids out.
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_exp[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= ram_en_b;
      pipe_exp[0] <= pattern(ram_addr_b, seed);
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_exp[i] <= pipe_exp[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (state == IDLE && start) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (pipe_vld[RD_LATENCY-1] && ram_rd_data != pipe_exp[RD_LATENCY-1]) begin
      err <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ram_wr_rd_check.sv
// Bench for ram_wr_rd_check: behavioural RAM models with port-B fault injection and
// a pass-level reference model (seed history, expected schedule, expected mismatch count).
module tb_ram_wr_rd_check;

  localparam int AW = 7, DW = 8, D = 128, RL = 1;
  localparam int AW_B = 8, D_B = 256, RL_B = 2;

  logic clk = 1'b0;
  logic rst_n, start, start_b;

  logic          en_a, wea, en_b, busy, done, err;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wr_data, rd_data;
  logic [7:0]    err_cnt;

  logic            en_a_b, wea_b, en_b_b, busy_b, done_b, err_b;
  logic [AW_B-1:0] addr_a_b, addr_b_b;
  logic [DW-1:0]   wr_data_b, rd_data_b;
  logic [7:0]      err_cnt_b;

  ram_wr_rd_check u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ram_en_a(en_a), .ram_wea(wea), .ram_addr_a(addr_a), .ram_wr_data(wr_data),
    .ram_en_b(en_b), .ram_addr_b(addr_b), .ram_rd_data(rd_data),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  ram_wr_rd_check #(.ADDR_W(AW_B), .DATA_W(DW), .DEPTH(D_B), .RD_LATENCY(RL_B)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .ram_en_a(en_a_b), .ram_wea(wea_b), .ram_addr_a(addr_a_b), .ram_wr_data(wr_data_b),
    .ram_en_b(en_b_b), .ram_addr_b(addr_b_b), .ram_rd_data(rd_data_b),
    .busy(busy_b), .done(done_b), .err(err_b), .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  // Simple dual-port RAM models; small one has a per-address fault map, big one faults every read.
  logic [DW-1:0] mem_s [D];
  logic [DW-1:0] mem_b [D_B];
  bit            fault_s [D];
  logic [DW-1:0] stage_b;

  always @(posedge clk) begin
    if (en_a && wea) mem_s[addr_a] <= wr_data;
    if (en_b) rd_data <= mem_s[addr_b] ^ (fault_s[addr_b] ? 8'h01 : 8'h00);
  end

  always @(posedge clk) begin
    if (en_a_b && wea_b) mem_b[addr_a_b] <= wr_data_b;
    if (en_b_b) stage_b <= mem_b[addr_b_b] ^ 8'h01;
    rd_data_b <= stage_b;
  end

  int n_cmp = 0, n_bad = 0;
  int seed_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  function automatic int faults_expected();
    int c = 0;
    for (int i = 0; i < D; i++) if (fault_s[i]) c++;
    return (c > 255) ? 255 : c;
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < D; i++) fault_s[i] = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int exp_cnt);
    check({tag, ".ctl"}, {en_a, wea, en_b, busy, done}, 0);
    check({tag, ".bus"}, {addr_a, addr_b, wr_data}, 0);
    check({tag, ".err"}, {err, err_cnt}, {(exp_cnt > 0) ? 1'b1 : 1'b0, 8'(exp_cnt)});
  endtask

  // One full pass from an IDLE sample point; returns at the sample point of the following IDLE cycle.
  task automatic run_pass(input bit hold);
    int exp_cnt = faults_expected();
    int done_n  = 2 * D + RL + 1;
    bit w, r;
    start = 1'b1;
    sample();
    for (int n = 1; n <= done_n; n++) begin
      w = (n <= D);
      r = (n > D) && (n <= 2 * D);
      check($sformatf("ctl@%0d", n), {en_a, wea, en_b, busy, done}, {w, w, r, 1'b1, n == done_n});
      if (w) check($sformatf("wr@%0d", n), {addr_a, wr_data}, {7'(n - 1), 8'((n - 1 + seed_m) % 256)});
      if (r) check($sformatf("rd@%0d", n), addr_b, n - 1 - D);
      if (n == 1) check("clr", {err, err_cnt}, 0);
      if (n == done_n) check("result", {err, err_cnt}, {(exp_cnt > 0) ? 1'b1 : 1'b0, 8'(exp_cnt)});
      start = hold ? 1'b1 : ((n < done_n) ? 1'($urandom_range(0, 1)) : 1'b0);
      sample();
    end
    seed_m = (seed_m + 1) % 256;
    check_idle("post", exp_cnt);
  endtask

  initial begin
    int n, k;
    rst_n = 1'b0; start = 1'b0; start_b = 1'b0;
    clear_faults();
    #1;
    check_idle("rst", 0);
    check("rst.big", {busy_b, done_b, err_b, err_cnt_b, en_a_b, en_b_b}, 0);
    repeat (3) sample();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin sample(); check_idle("idle0", 0); end

    run_pass(0);                       // seed 0: data = addr
    run_pass(0);                       // seed 1: addr 127 writes 0x80

    fault_s[5] = 1'b1;
    run_pass(0);
    for (int i = 0; i < 5; i++) begin sample(); check_idle("hold", 1); end
    clear_faults();
    run_pass(0);

    for (int i = 0; i < D; i++) fault_s[i] = 1'b1;
    run_pass(0);
    clear_faults();

    for (int p = 0; p < 4; p++) begin
      clear_faults();
      k = $urandom_range(0, 3);
      repeat (k) fault_s[$urandom_range(0, D - 1)] = 1'b1;
      run_pass(0);
    end
    clear_faults();

    run_pass(1);                       // start held: back-to-back passes
    run_pass(1);
    run_pass(0);

    // Abort in the middle of WRITE at address 60.
    start = 1'b1;
    sample();
    n = 1;
    while (n < 61) begin
      start = 1'($urandom_range(0, 1));
      sample();
      n++;
    end
    check("abort.addr", {en_a, addr_a}, {1'b1, 7'd60});
    #1 rst_n = 1'b0;
    #1;
    check_idle("abort", 0);
    start = 1'b0;
    repeat (2) sample();
    #4 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin sample(); check_idle("after", 0); end
    seed_m = 0;
    run_pass(0);

    // Big configuration: every read faulted, 256 mismatches saturate at 255.
    start_b = 1'b1;
    sample();
    start_b = 1'b0;
    n = 1;
    while (!done_b && n < 1000) begin sample(); n++; end
    check("big.done_at", n, 2 * D_B + RL_B + 1);
    check("big.result", {err_b, err_cnt_b}, {1'b1, 8'd255});
    sample();
    check("big.hold", {busy_b, done_b, err_b, err_cnt_b}, {1'b0, 1'b0, 1'b1, 8'd255});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_wr_rd_check.md
RAM_WR_RD_CHECK -- requirements
Module: ram_wr_rd_check

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 7, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 128, number of words exercised, DEPTH <= 2^ADDR_W.
- RD_LATENCY, 1, RAM port-B read latency in clocks, range 1..2.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock domain; all logic on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, request one write-then-readback pass.
- ram_en_a, out, 1, RAM port-A enable.
- ram_wea, out, 1, RAM port-A write enable.
- ram_addr_a, out, ADDR_W, port-A address.
- ram_wr_data, out, DATA_W, port-A write data.
- ram_en_b, out, 1, RAM port-B read enable.
- ram_addr_b, out, ADDR_W, port-B address.
- ram_rd_data, in, DATA_W, port-B read data, valid RD_LATENCY clocks after ram_en_b.
- busy, out, 1, pass in progress.
- done, out, 1, one-clock pulse at the end of a pass.
- err, out, 1, sticky mismatch flag for the current or last pass.
- err_cnt, out, 8, mismatch count, saturating at 255.

REQ-003 One clock; reset is asynchronous and active-low (clk, rst_n), polarity and synchronicity fixed.

Function
REQ-004 FSM states IDLE, WRITE, READ, DRAIN, DONE; every output registered.
REQ-005 IDLE: when start=1, capture the seed, clear err and err_cnt, and go to WRITE on the next clock.
REQ-006 start is ignored in every state other than IDLE; no queuing.
REQ-007 WRITE:
- ram_en_a=1 and ram_wea=1 for exactly DEPTH clocks.
- ram_addr_a runs 0..DEPTH-1, incrementing by 1 per clock.
- ram_wr_data = (ram_addr_a + seed) mod 2^DATA_W, with the address zero-extended or truncated to DATA_W.
- After address DEPTH-1, go to READ.
REQ-008 READ:
- ram_en_b=1 for exactly DEPTH clocks.
- ram_addr_b runs 0..DEPTH-1.
- ram_en_a=0 and ram_wea=0 throughout.
- After address DEPTH-1, go to DRAIN.
REQ-009 Expected data and a valid bit are carried through an RD_LATENCY-deep shift pipeline aligned to ram_rd_data.
- Compare only when the valid bit is set.
- ram_rd_data is ignored otherwise.
REQ-010 On each valid mismatch:
- set err=1;
- increment err_cnt by 1, holding at 255 (no wrap).
REQ-011 DRAIN lasts exactly RD_LATENCY clocks with ram_en_b=0; the last word is compared here, then go to DONE.
REQ-012 DONE lasts one clock:
- done=1;
- seed <= seed+1 (mod 2^DATA_W);
- then go to IDLE.
REQ-013 busy=1 in WRITE, READ, DRAIN and DONE, and 0 in IDLE.
REQ-014 Timing with start accepted at edge T:
- first write at T+1;
- first read at T+1+DEPTH;
- done high in cycle T+1+2*DEPTH+RD_LATENCY.
REQ-015 When start is high in the same cycle done is high, it is ignored; a new pass needs start while in IDLE.
REQ-016 Address counters never exceed DEPTH-1; when DEPTH = 2^ADDR_W, the terminal address is detected by compare, not by overflow.
REQ-017 In IDLE, all RAM enables are 0, and addresses and write data are held at 0.
REQ-018 err and err_cnt hold their values after DONE until the next accepted start.

Reset
REQ-019 rst_n=0 asynchronously forces:
- state IDLE;
- all RAM outputs 0;
- busy=0, done=0, err=0, err_cnt=0;
- seed=0;
- comparison pipeline cleared.
REQ-020 Reset during any state aborts the pass: no done pulse, no seed increment, and no further RAM access until a new start after release.
REQ-021 After rst_n deasserts, the block stays in IDLE until start=1 is sampled.

Verification
REQ-022 The bench uses a behavioural simple dual-port RAM model (128x8, read latency RD_LATENCY) with optional fault injection on port-B data.
REQ-023 Directed scenarios:
- Defaults, start pulse at T, no faults -> writes addr 0..127 with data 0x00..0x7F; done at T+258; err=0; err_cnt=0.
- Second pass after the first -> seed=1; data = addr+1, so addr 127 writes 0x80; err=0.
- Fault: read data at addr 5 XOR 0x01 -> err=1 and err_cnt=1 after done; both stay unchanged until the next start, which clears them.
- Fault on every read -> err_cnt saturates at 255 (128 per pass, cleared per pass, so force with DEPTH=128, DATA_W=8 and check 128); a separate 2^ADDR_W=256 configuration checks the hold at 255.
- start held high continuously -> back-to-back passes separated by exactly 1 IDLE cycle; start pulses during busy change nothing.
- rst_n low at WRITE addr 60 -> all outputs 0 immediately (asynchronous); no done; seed stays 0; the next pass writes data = addr.
